gray_ptr_rd_ctrl: RTL and testbench

- Read-side controller for a gray-pointer crossing, i.e. the read end of an async FIFO.
- Receives the remote writer's gray-coded pointer, synchronizes it into the local clock domain, and decodes it to binary.
- Tracks the local read pointer and grants pops only when data is present.
- Returns the read pointer to the writer as a registered gray code.
- Sits between a dual-port RAM and the write-side controller.

---
 rtl/gray_ptr_rd_ctrl.sv | 96 +++++++++
 tb/tb_gray_ptr_rd_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/gray_ptr_rd_ctrl.sv
// Read-side pointer controller of an async FIFO: synchronizes the writer's gray pointer,
// derives fill level and grants pops. Optional integrity check under GRAY_PTR_ERR_CHECK_EN.
module gray_ptr_rd_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned PW         = ADDR_WIDTH + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [PW-1:0]         wr_ptr_gray_i,
    input  logic                  rd_en_i,
    output logic                  rd_ok_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic [PW-1:0]         rd_ptr_gray_o,
    output logic                  empty_o,
`ifdef GRAY_PTR_ERR_CHECK_EN
    output logic                  err_o,
`endif
    output logic [PW-1:0]         level_o
);

    localparam logic [PW-1:0] DEPTH = PW'(1) << ADDR_WIDTH;

    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] wr_sync;
    logic [PW-1:0] wr_bin;
    logic [PW-1:0] rd_bin_q, rd_bin_d;
    logic [PW-1:0] rd_gray_q, rd_gray_d;
    logic [PW-1:0] level;
    logic          rd_ok;

    // Plain flop chain: nothing may sit between stages.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= wr_ptr_gray_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign wr_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        wr_bin         = '0;
        wr_bin[PW-1]   = wr_sync[PW-1];
        for (int i = PW - 2; i >= 0; i--) wr_bin[i] = wr_bin[i+1] ^ wr_sync[i];
    end

    assign level = wr_bin - rd_bin_q;
    assign rd_ok = rd_en_i & (level != '0);

    always_comb begin
        rd_bin_d  = rd_ok ? rd_bin_q + PW'(1) : rd_bin_q;
        rd_gray_d = rd_bin_d ^ (rd_bin_d >> 1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_bin_q  <= '0;
            rd_gray_q <= '0;
        end else begin
            rd_bin_q  <= rd_bin_d;
            rd_gray_q <= rd_gray_d;
        end
    end

`ifdef GRAY_PTR_ERR_CHECK_EN
    logic [PW-1:0] wr_prev_q;
    logic [PW-1:0] step;
    logic          err_q, err_d;

    // More than one toggled bit between consecutive synced values is an illegal gray step.
    assign step  = wr_sync ^ wr_prev_q;
    assign err_d = err_q | (|(step & (step - PW'(1)))) | (level > DEPTH);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_prev_q <= '0;
            err_q     <= 1'b0;
        end else begin
            wr_prev_q <= wr_sync;
            err_q     <= err_d;
        end
    end

    assign err_o = err_q;
`endif

    assign rd_ok_o       = rd_ok;
    assign rd_addr_o     = rd_bin_q[ADDR_WIDTH-1:0];
    assign rd_ptr_gray_o = rd_gray_q;
    assign empty_o       = (level == '0);
    assign level_o       = level;

endmodule

// File: tb/tb_gray_ptr_rd_ctrl.sv
// Randomized and directed bench for gray_ptr_rd_ctrl against an occupancy-count model.
module tb_gray_ptr_rd_ctrl;
    localparam int unsigned AW  = 4;
    localparam int unsigned S   = 2;
    localparam int unsigned PW  = AW + 1;
    localparam int          MOD = 1 << PW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [PW-1:0] wr_gray = '0;
    logic          rd_en = 1'b0;
    logic          rd_ok;
    logic [AW-1:0] rd_addr;
    logic [PW-1:0] rd_ptr_gray;
    logic          empty;
    logic [PW-1:0] level;
`ifdef GRAY_PTR_ERR_CHECK_EN
    logic          err;
`endif

    gray_ptr_rd_ctrl #(
        .ADDR_WIDTH  (AW),
        .SYNC_STAGES (S)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .wr_ptr_gray_i (wr_gray),
        .rd_en_i       (rd_en),
        .rd_ok_o       (rd_ok),
        .rd_addr_o     (rd_addr),
        .rd_ptr_gray_o (rd_ptr_gray),
        .empty_o       (empty),
`ifdef GRAY_PTR_ERR_CHECK_EN
        .err_o         (err),
`endif
        .level_o       (level)
    );

    always #5 clk = ~clk;

    int unsigned   n_checks = 0;
    int unsigned   n_pass   = 0;
    int unsigned   ok_seen  = 0;
    bit            model_valid = 0;
    logic [PW-1:0] sync_m[$];   // gray values in flight, newest first
    int            rd_m;        // read count mod 2**PW
    logic [PW-1:0] prev_m;
    bit            err_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int g2b(input logic [PW-1:0] g);
        logic [PW-1:0] b = '0;
        for (int i = 0; i < int'(PW); i++) b[i] = ^(g >> i);
        return int'(b);
    endfunction

    function automatic int b2g(input int b);
        return (b ^ (b >> 1)) % MOD;
    endfunction

    function automatic int m_level();
        return (g2b(sync_m[S-1]) - rd_m + MOD) % MOD;
    endfunction

    task automatic model_reset();
        sync_m = {};
        for (int i = 0; i < int'(S); i++) sync_m.push_back('0);
        rd_m   = 0;
        prev_m = '0;
        err_m  = 0;
        model_valid = 1;
    endtask

    // Apply inputs, compare outputs, clock once and advance the model.
    task automatic cycle(input logic rst, input int g, input logic en);
        int lv = 0;
        bit ok = 0;
        rst_n   = rst;
        wr_gray = PW'(g);
        rd_en   = en;
        #1;
        if (model_valid) begin
            lv = m_level();
            ok = en && (lv != 0);
            check("level", 32'(level), 32'(lv));
            check("empty", 32'(empty), 32'(lv == 0));
            check("rd_ok", 32'(rd_ok), 32'(ok));
            check("rd_addr", 32'(rd_addr), 32'(rd_m % (1 << AW)));
            check("rd_ptr_gray", 32'(rd_ptr_gray), 32'(b2g(rd_m)));
`ifdef GRAY_PTR_ERR_CHECK_EN
            check("err", 32'(err), 32'(err_m));
`endif
            if (rd_ok === 1'b1) ok_seen++;
        end
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else if (model_valid) begin
            if ($countones(sync_m[S-1] ^ prev_m) > 1 || lv > (1 << AW)) err_m = 1;
            prev_m = sync_m[S-1];
            if (ok) rd_m = (rd_m + 1) % MOD;
            sync_m.push_front(PW'(g));
            void'(sync_m.pop_back());
        end
        #1;
    endtask

    initial begin
        int wr_cnt;
        int seq[5] = '{1, 3, 2, 6, 7};

        // Reset with a nonzero incoming pointer, then release.
        cycle(0, 3, 0);
        cycle(0, 3, 0);
        check("t1_rst_level", 32'(level), 0);
        check("t1_rst_empty", 32'(empty), 1);
        cycle(1, 3, 0);
        cycle(1, 3, 0);
        check("t1_level", 32'(level), 2);
        check("t1_not_empty", 32'(empty), 0);

        // Streaming: write 1..5, then drain.
        cycle(0, 0, 0);
        for (int b = 1; b <= 5; b++) cycle(1, b2g(b), 0);
        cycle(1, b2g(5), 0);
        cycle(1, b2g(5), 0);
        check("t2_level5", 32'(level), 5);
        ok_seen = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1, b2g(5), 1);
            if (i < 5) check("t2_gray_seq", 32'(rd_ptr_gray), 32'(seq[i]));
        end
        check("t2_ok_count", 32'(ok_seen), 5);
        check("t2_empty", 32'(empty), 1);

        // Empty pops are ignored.
        for (int i = 0; i < 3; i++) cycle(1, b2g(5), 1);
        check("t3_gray_hold", 32'(rd_ptr_gray), 32'h07);
        check("t3_addr_hold", 32'(rd_addr), 5);

        // Wrap: bring rd to 28 and wr to 31, then wr to 0.
        cycle(0, 0, 0);
        for (int c = 0; c < 40; c++) begin
            wr_cnt = (c + 1 > 31) ? 31 : c + 1;
            cycle(1, b2g(wr_cnt), logic'(rd_m < 28));
        end
        check("t4_rd_gray28", 32'(rd_ptr_gray), 32'h12);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        check("t4_level4", 32'(level), 4);
        for (int i = 0; i < 4; i++) cycle(1, 0, 1);
        check("t4_gray0", 32'(rd_ptr_gray), 0);
        check("t4_addr0", 32'(rd_addr), 0);
        check("t4_empty", 32'(empty), 1);

        // Full, then pop while the writer advances.
        cycle(0, 0, 0);
        for (int b = 1; b <= 16; b++) cycle(1, b2g(b), 0);
        cycle(1, b2g(16), 0);
        cycle(1, b2g(16), 0);
        check("t5_full", 32'(level), 16);
        check("t5_not_empty", 32'(empty), 0);
        cycle(1, b2g(17), 1);
        cycle(1, b2g(17), 0);
        cycle(1, b2g(17), 0);
        check("t5_level16", 32'(level), 16);

        // Random traffic with occasional resets.
        cycle(0, 0, 0);
        wr_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                wr_cnt = 0;
                cycle(0, 0, logic'($urandom_range(0, 1)));
            end else begin
                if ($urandom_range(0, 1) == 1 && ((wr_cnt - rd_m + MOD) % MOD) < (1 << AW))
                    wr_cnt = (wr_cnt + 1) % MOD;
                cycle(1, b2g(wr_cnt), logic'($urandom_range(0, 2) != 0));
            end
        end

`ifdef GRAY_PTR_ERR_CHECK_EN
        cycle(0, 0, 0);
        cycle(1, 0, 0);
        cycle(1, 3, 0);
        cycle(1, 3, 0);
        cycle(1, 3, 0);
        check("t6_err_set", 32'(err), 1);
        for (int b = 3; b <= 6; b++) cycle(1, b2g(b), 1);
        check("t6_err_sticky", 32'(err), 1);
        cycle(0, 0, 0);
        check("t6_err_clear", 32'(err), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
